// File: rtl/tt_sweep_pkg.sv
// Shared types, sizing constants and the input projection used by the sweep controller.
package tt_sweep_pkg;

    localparam int TT_N_IN     = 8;
    localparam int TT_WORD_W   = 8;
    localparam int TT_NUM_VEC  = 1 << TT_N_IN;
    localparam int TT_NUM_WORD = TT_NUM_VEC / TT_WORD_W;
    // Working width for the projection helper; any N_IN below this fits.
    localparam int TT_MAX_IN   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sweep_state_e;

    // Forced inputs take their value from val, the rest follow the sweep index.
    function automatic logic [TT_MAX_IN-1:0] project_vec(
        input logic [TT_MAX_IN-1:0] idx,
        input logic [TT_MAX_IN-1:0] mask,
        input logic [TT_MAX_IN-1:0] val
    );
        return (idx & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/tt_word_pack.sv
// Bit-serial to word packer with a single-entry valid/ready output register.
module tt_word_pack
    import tt_sweep_pkg::*;
#(
    parameter int WORD_W = TT_WORD_W,
    localparam int POS_W = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_sample,
    input  logic              i_bit,
    input  logic [POS_W-1:0]  i_pos,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_can_accept,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last
);

    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic [WORD_W-1:0] w_bits;
    logic              w_word_end;
    logic              w_handshake;

    // Current partial word with the incoming sample merged into its slot.
    always_comb begin
        w_bits        = r_shift;
        w_bits[i_pos] = i_bit;
    end

    assign w_word_end   = i_sample && (i_pos == POS_W'(WORD_W - 1));
    assign w_handshake  = r_valid && i_ready;
    assign o_can_accept = !r_valid || i_ready;

    // Accumulate samples; the controller only samples a word-ending bit when the output register can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
        end else if (i_sample) begin
            r_shift <= w_bits;
        end
    end

    // Output register: a reload wins over the clear that a handshake would otherwise cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_word_end) begin
            r_data  <= w_bits;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (w_handshake) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps a combinational function over its full input space and streams back its truth table.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = TT_N_IN,
    parameter int WORD_W = TT_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [N_IN-1:0]   i_fix_mask,
    input  logic [N_IN-1:0]   i_fix_val,
    output logic [N_IN-1:0]   o_f_x,
    input  logic              i_f_y,
    output logic [WORD_W-1:0] o_tt_data,
    output logic              o_tt_valid,
    input  logic              i_tt_ready,
    output logic              o_tt_last,
    output logic [N_IN:0]     o_ones_cnt,
    output logic              o_busy,
    output logic              o_done
);

    localparam int POS_W = $clog2(WORD_W);

    sweep_state_e      r_state;
    logic [N_IN-1:0]   r_idx;
    logic [N_IN-1:0]   r_mask;
    logic [N_IN-1:0]   r_val;
    logic [N_IN-1:0]   r_f_x;
    logic [N_IN:0]     r_ones;
    logic              r_busy;
    logic              r_done;

    logic [POS_W-1:0]  w_pos;
    logic              w_word_end;
    logic              w_last_sample;
    logic              w_can_accept;
    logic              w_advance;
    logic              w_clear;
    logic              w_last_accept;
    logic [N_IN-1:0]   w_next_idx;

    // Narrow wrapper around the package projection for this instance's width.
    function automatic logic [N_IN-1:0] vec_of(
        input logic [N_IN-1:0] idx,
        input logic [N_IN-1:0] mask,
        input logic [N_IN-1:0] val
    );
        logic [TT_MAX_IN-1:0] w_full;
        w_full = project_vec(TT_MAX_IN'(idx), TT_MAX_IN'(mask), TT_MAX_IN'(val));
        return w_full[N_IN-1:0];
    endfunction

    assign w_pos         = r_idx[POS_W-1:0];
    assign w_word_end    = (w_pos == POS_W'(WORD_W - 1));
    assign w_last_sample = (r_idx == {N_IN{1'b1}});
    assign w_next_idx    = r_idx + N_IN'(1);
    assign w_advance     = (r_state == ST_RUN) && (!w_word_end || w_can_accept);
    assign w_clear       = (r_state == ST_IDLE) && i_start;
    assign w_last_accept = o_tt_valid && i_tt_ready && o_tt_last;

    // Sweep sequencer: owns the index, the applied vector, the ones count and the status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_mask  <= '0;
            r_val   <= '0;
            r_f_x   <= '0;
            r_ones  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mask  <= i_fix_mask;
                        r_val   <= i_fix_val;
                        r_f_x   <= vec_of('0, i_fix_mask, i_fix_val);
                        r_idx   <= '0;
                        r_ones  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        r_ones <= r_ones + {{N_IN{1'b0}}, i_f_y};
                        r_idx  <= w_next_idx;
                        r_f_x  <= vec_of(w_next_idx, r_mask, r_val);
                        if (w_last_sample) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_last_accept) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    tt_word_pack #(
        .WORD_W (WORD_W)
    ) u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_sample     (w_advance),
        .i_bit        (i_f_y),
        .i_pos        (w_pos),
        .i_last       (w_last_sample),
        .i_ready      (i_tt_ready),
        .o_can_accept (w_can_accept),
        .o_data       (o_tt_data),
        .o_valid      (o_tt_valid),
        .o_last       (o_tt_last)
    );

    assign o_f_x      = r_f_x;
    assign o_ones_cnt = r_ones;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: table of full sweeps plus a mid-sweep reset sequence.
module tb_tt_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_fix_mask;
    logic [7:0] i_fix_val;
    logic [7:0] o_f_x;
    logic       i_f_y;
    logic [7:0] o_tt_data;
    logic       o_tt_valid;
    logic       i_tt_ready;
    logic       o_tt_last;
    logic [8:0] o_ones_cnt;
    logic       o_busy;
    logic       o_done;

    int checkCount = 0;
    int errCount   = 0;
    int tbMode     = 0;

    typedef struct {
        int       mode;
        logic [7:0] mask;
        logic [7:0] val;
        int       stallWord;
        int       stallLen;
        int       pulseEdge;
        int       freezeIdx;
        int       expOnes;
        logic [7:0] expW0;
        logic [7:0] expW2;
        int       expDone;
    } sweep_vec_t;

    sweep_vec_t rows [8];

    tt_sweep_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_fix_mask (i_fix_mask),
        .i_fix_val  (i_fix_val),
        .o_f_x      (o_f_x),
        .i_f_y      (i_f_y),
        .o_tt_data  (o_tt_data),
        .o_tt_valid (o_tt_valid),
        .i_tt_ready (i_tt_ready),
        .o_tt_last  (o_tt_last),
        .o_ones_cnt (o_ones_cnt),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural benchmark function: mode 0 is f=x0, mode 1 is f=x7^x4.
    always_comb begin
        i_f_y = 1'b0;
        if (tbMode == 0) i_f_y = o_f_x[0];
        else             i_f_y = o_f_x[7] ^ o_f_x[4];
    end

    function automatic logic [7:0] vecOf(input int i, input logic [7:0] m, input logic [7:0] v);
        logic [7:0] ii;
        ii = i[7:0];
        return (ii & ~m) | (v & m);
    endfunction

    function automatic logic bitOf(input int mode, input logic [7:0] x);
        if (mode == 0) return x[0];
        return x[7] ^ x[4];
    endfunction

    function automatic logic [7:0] expWord(input int mode, input logic [7:0] m, input logic [7:0] v, input int k);
        logic [7:0] w;
        w = '0;
        for (int b = 0; b < 8; b++) w[b] = bitOf(mode, vecOf(k * 8 + b, m, v));
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Runs one full sweep, acting as consumer, and checks stream, timing and counters.
    task automatic applyStimulus(input sweep_vec_t r);
        logic [7:0] gotWords [64];
        logic       gotLast  [64];
        int nWords, nDone, doneEdge, firstValid, stallCnt, lastCnt, e;
        logic prevStall;
        logic [7:0] prevData;
        nWords = 0; nDone = 0; doneEdge = -1; firstValid = -1; stallCnt = 0; lastCnt = 0;
        prevStall = 1'b0; prevData = '0;
        @(negedge clk);
        tbMode     = r.mode;
        i_fix_mask = r.mask;
        i_fix_val  = r.val;
        i_tt_ready = 1'b1;
        i_start    = 1'b1;
        @(posedge clk);
        e = 0;
        forever begin
            @(negedge clk);
            i_start = (e + 1 == r.pulseEdge);
            if (e + 1 == r.pulseEdge) begin
                i_fix_mask = ~r.mask;
                i_fix_val  = ~r.val;
            end
            if (e == 0) begin
                checkOutput("fx_after_start", 32'(o_f_x), 32'(vecOf(0, r.mask, r.val)));
                checkOutput("busy_after_start", 32'(o_busy), 32'd1);
                checkOutput("ones_cleared", 32'(o_ones_cnt), 32'd0);
            end
            if (e == 42) checkOutput("fx_at_edge42", 32'(o_f_x), 32'(vecOf(r.freezeIdx, r.mask, r.val)));
            if (prevStall) begin
                checkOutput("stall_valid_held", 32'(o_tt_valid), 32'd1);
                checkOutput("stall_data_held", 32'(o_tt_data), 32'(prevData));
            end
            if (o_tt_valid && firstValid < 0) firstValid = e;
            if (r.stallWord >= 0 && o_tt_valid && nWords == r.stallWord && stallCnt < r.stallLen) begin
                i_tt_ready = 1'b0;
                stallCnt++;
            end else begin
                i_tt_ready = 1'b1;
            end
            prevStall = o_tt_valid && !i_tt_ready;
            prevData  = o_tt_data;
            if (o_tt_valid && i_tt_ready) begin
                if (nWords < 64) begin
                    gotWords[nWords] = o_tt_data;
                    gotLast[nWords]  = o_tt_last;
                end
                if (o_tt_last) lastCnt++;
                nWords++;
            end
            if (o_done) begin
                nDone++;
                doneEdge = e;
                checkOutput("busy_low_at_done", 32'(o_busy), 32'd0);
            end
            if (doneEdge >= 0 && e >= doneEdge + 3) break;
            if (e >= 700) begin
                checkOutput("sweep_timeout", 32'(e), 32'd0);
                break;
            end
            @(posedge clk);
            e++;
        end
        i_fix_mask = r.mask;
        i_fix_val  = r.val;
        checkOutput("word_count", 32'(nWords), 32'd32);
        checkOutput("done_count", 32'(nDone), 32'd1);
        checkOutput("done_edge", 32'(doneEdge), 32'(r.expDone));
        checkOutput("first_valid_edge", 32'(firstValid), 32'd8);
        checkOutput("ones_cnt_final", 32'(o_ones_cnt), 32'(r.expOnes));
        checkOutput("last_flag_count", 32'(lastCnt), 32'd1);
        if (nWords == 32) begin
            checkOutput("word0_hand", 32'(gotWords[0]), 32'(r.expW0));
            checkOutput("word2_hand", 32'(gotWords[2]), 32'(r.expW2));
            checkOutput("last_on_word31", 32'(gotLast[31]), 32'd1);
            for (int k = 0; k < 32; k++)
                checkOutput($sformatf("stream_word%0d", k), 32'(gotWords[k]), 32'(expWord(r.mode, r.mask, r.val, k)));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_fx"},    32'(o_f_x),      32'd0);
        checkOutput({tag, "_data"},  32'(o_tt_data),  32'd0);
        checkOutput({tag, "_valid"}, 32'(o_tt_valid), 32'd0);
        checkOutput({tag, "_last"},  32'(o_tt_last),  32'd0);
        checkOutput({tag, "_ones"},  32'(o_ones_cnt), 32'd0);
        checkOutput({tag, "_busy"},  32'(o_busy),     32'd0);
        checkOutput({tag, "_done"},  32'(o_done),     32'd0);
    endtask

    initial begin
        // mode mask val stallWord stallLen pulse freezeIdx ones w0 w2 done
        rows[0] = '{0, 8'h00, 8'h00, -1, 0,  0, 42, 128, 8'hAA, 8'hAA, 257};
        rows[1] = '{1, 8'h00, 8'h00, -1, 0,  0, 42, 128, 8'h00, 8'hFF, 257};
        rows[2] = '{0, 8'h01, 8'h01, -1, 0,  0, 42, 256, 8'hFF, 8'hFF, 257};
        rows[3] = '{0, 8'h01, 8'h00, -1, 0,  0, 42,   0, 8'h00, 8'h00, 257};
        rows[4] = '{1, 8'h80, 8'h80, -1, 0,  0, 42, 128, 8'hFF, 8'h00, 257};
        // Word 3 held 12 cycles: word 4 completes at edge 40 and is blocked 5 cycles at vec(39).
        rows[5] = '{0, 8'h00, 8'h00,  3, 12, 0, 39, 128, 8'hAA, 8'hAA, 262};
        rows[6] = '{0, 8'h00, 8'h00, -1, 0, 50, 42, 128, 8'hAA, 8'hAA, 257};
        // Short stall on word 0 is absorbed before word 1 completes.
        rows[7] = '{1, 8'h00, 8'h00,  0, 3,  0, 42, 128, 8'h00, 8'hFF, 257};

        rst_n = 1'b0; i_start = 1'b0; i_fix_mask = '0; i_fix_val = '0; i_tt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) begin
            $display("[TB] sweep row %0d", t);
            applyStimulus(rows[t]);
        end

        // Reset abandons a sweep in progress, then a new sweep must be complete.
        @(negedge clk);
        tbMode = 1; i_fix_mask = '0; i_fix_val = '0; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        checkOutput("busy_before_reset", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midsweep_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset_valid", 32'(o_tt_valid), 32'd0);
        applyStimulus(rows[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, errCount);
        $finish;
    end

endmodule
